dma64_read_arbiter: RTL and testbench
=====================================

Name: dma64_read_arbiter

Overview:
- Shares one ESP 64-bit DMA read port (ctrl + chnl) between N_CLIENTS accelerator-side requesters, for example two mem-copier engines.
- Round-robin grant per burst. The grant is held from the ctrl handshake until the last data beat of that burst.
- The master side connects directly to the tile's dma_read_ctrl_* / dma_read_chnl_* ports. A second instance is not used for writes; the write arbiter is a separate block.

Parameters:
- N_CLIENTS, 2: number of requesters (2..8).
- IDW, 3: width of grant_id; must satisfy 2**IDW >= N_CLIENTS.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- cl_ctrl_valid  in  N_CLIENTS  per-client read request.
- cl_ctrl_ready  out  N_CLIENTS  per-client request accepted.
- cl_ctrl_index  in  32*N_CLIENTS  per-client start word index; client i occupies bits [32i+31:32i].
- cl_ctrl_length  in  32*N_CLIENTS  per-client burst length in beats.
- cl_ctrl_size  in  3*N_CLIENTS  per-client beat size code.
- cl_chnl_valid  out  N_CLIENTS  beat valid toward the granted client.
- cl_chnl_ready  in  N_CLIENTS  per-client beat ready.
- cl_chnl_data  out  64  beat data, broadcast to all clients.
- dma_read_ctrl_valid  out  1  master request.
- dma_read_ctrl_ready  in  1  master accept.
- dma_read_ctrl_data_index  out  32  latched index.
- dma_read_ctrl_data_length  out  32  latched length.
- dma_read_ctrl_data_size  out  3  latched size.
- dma_read_ctrl_data_user  out  6  constant 0.
- dma_read_chnl_valid  in  1  master beat valid.
- dma_read_chnl_ready  out  1  master beat ready.
- dma_read_chnl_data  in  64  master beat data.
- grant_id  out  IDW  currently or last granted client.
- busy  out  1  high in any state other than IDLE.
- debug  out  32  {29'd0, state}.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, rr_ptr=0.
  - dma_read_ctrl_valid=0; index, length and size registers=0.
  - beat counter=0, grant_id=0, busy=0.
  - Reset mid-burst abandons the burst; no beats are forwarded afterwards.
- FSM states are IDLE, CTRL and DATA.
- IDLE:
  - If any cl_ctrl_valid is high, pick the first requester at or after rr_ptr (wrapping modulo N_CLIENTS).
  - Register grant_id, index, length and size from that client.
  - If length != 0, go to CTRL the next cycle.
  - If length == 0: pulse cl_ctrl_ready[g] for one cycle in IDLE, issue no master request, set rr_ptr=g+1 (mod N_CLIENTS), stay in IDLE.
- CTRL:
  - dma_read_ctrl_valid=1.
  - Combinationally, cl_ctrl_ready[g]=dma_read_ctrl_ready; all other cl_ctrl_ready bits are 0.
  - On dma_read_ctrl_ready: beat counter=length, go to DATA.
  - Index, length and size stay stable while valid is high.
- DATA:
  - Combinationally, cl_chnl_valid[g]=dma_read_chnl_valid and dma_read_chnl_ready=cl_chnl_ready[g]; the other cl_chnl_valid bits are 0.
  - cl_chnl_data=dma_read_chnl_data at all times.
  - On each beat handshake the counter decrements by 1.
  - On the handshake where counter==1: go to IDLE and set rr_ptr=g+1 (mod N_CLIENTS).
  - Backpressure from the client stalls the master. Beats are never dropped or duplicated.
- Outside DATA, dma_read_chnl_ready=0 and all cl_chnl_valid bits are 0.
- Latency:
  - Request seen in IDLE -> dma_read_ctrl_valid high 1 cycle later.
  - Last beat -> earliest next dma_read_ctrl_valid 2 cycles later (IDLE, then CTRL).
- Requests arriving while busy are held by the client, because cl_ctrl_ready stays low; they are arbitrated on the next IDLE cycle.
- The arbiter drops no request: a client that keeps valid high is granted within N_CLIENTS bursts.
- Lengths are 32-bit unsigned and the counter has no wrap.
- dma_read_chnl_valid while not in DATA is a protocol error. It is ignored, and no client sees it.
- grant_id holds its value in IDLE until the next grant.

Decomposition:
- Package dma64_arb_pkg:
  - state enum {IDLE, CTRL, DATA}.
  - DMA_SIZE_64 = 3'b011.
  - Width constants IDX_W=32, LEN_W=32, BEAT_W=64.
- Sub-module rr_pick (combinational): inputs req[N_CLIENTS] and ptr; outputs grant index and any_req. Verified standalone.

Test Plan:
- Single client 0 requests index=0x10, length=4; the master accepts after 2 cycles and sends 4 beats → cl_ctrl_ready[0] pulses in the accept cycle, client 0 receives 4 beats in order, busy drops after beat 4, rr_ptr=1.
- Clients 0 and 1 both request (length 3 and 2) in the same cycle after reset → client 0 is granted first, then client 1, with dma_read_ctrl_valid reasserting 2 cycles after client 0's last beat and grant_id going 0 then 1.
- Client 1 holds cl_chnl_ready low for 5 cycles mid-burst → dma_read_chnl_ready stays low for those cycles and no beat is lost; the beat count still ends at length.
- Client 0 requests length=0 → one-cycle cl_ctrl_ready[0] pulse, dma_read_ctrl_valid never rises, rr_ptr advances to 1.
- rst asserted during DATA with 2 beats remaining → all outputs reach reset values immediately without waiting for clk; after release, a new request from client 1 is granted with a clean counter.
- Both clients request continuously for 6 bursts → grants alternate 0,1,0,1,0,1.

Source files
------------

// File: rtl/dma64_read_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dma64_arb_pkg : shared types and widths for the DMA64 read arbiter   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package dma64_arb_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CTRL = 3'd1,
        DATA = 3'd2
    } state_t;

    localparam logic [2:0] DMA_SIZE_64 = 3'b011;

    localparam int IDX_W  = 32;
    localparam int LEN_W  = 32;
    localparam int BEAT_W = 64;

endpackage
`default_nettype wire

// File: rtl/dma64_read_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dma64_read_arbiter_if : client-side and tile-side DMA read signals   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface dma64_read_arbiter_if #(
    parameter int N_CLIENTS = 2,
    parameter int IDW       = 3
);
    import dma64_arb_pkg::*;

    logic [N_CLIENTS-1:0]       cl_ctrl_valid;
    logic [N_CLIENTS-1:0]       cl_ctrl_ready;
    logic [IDX_W*N_CLIENTS-1:0] cl_ctrl_index;
    logic [LEN_W*N_CLIENTS-1:0] cl_ctrl_length;
    logic [3*N_CLIENTS-1:0]     cl_ctrl_size;
    logic [N_CLIENTS-1:0]       cl_chnl_valid;
    logic [N_CLIENTS-1:0]       cl_chnl_ready;
    logic [BEAT_W-1:0]          cl_chnl_data;

    logic                       dma_read_ctrl_valid;
    logic                       dma_read_ctrl_ready;
    logic [IDX_W-1:0]           dma_read_ctrl_data_index;
    logic [LEN_W-1:0]           dma_read_ctrl_data_length;
    logic [2:0]                 dma_read_ctrl_data_size;
    logic [5:0]                 dma_read_ctrl_data_user;
    logic                       dma_read_chnl_valid;
    logic                       dma_read_chnl_ready;
    logic [BEAT_W-1:0]          dma_read_chnl_data;

    logic [IDW-1:0]             grant_id;
    logic                       busy;
    logic [31:0]                debug;

    // Arbiter view
    modport master (
        input  cl_ctrl_valid, cl_ctrl_index, cl_ctrl_length, cl_ctrl_size, cl_chnl_ready,
        output cl_ctrl_ready, cl_chnl_valid, cl_chnl_data,
        output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
        output dma_read_ctrl_data_size, dma_read_ctrl_data_user, dma_read_chnl_ready,
        input  dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
        output grant_id, busy, debug
    );

    // Environment view (clients plus tile DMA port)
    modport slave (
        output cl_ctrl_valid, cl_ctrl_index, cl_ctrl_length, cl_ctrl_size, cl_chnl_ready,
        input  cl_ctrl_ready, cl_chnl_valid, cl_chnl_data,
        input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
        input  dma_read_ctrl_data_size, dma_read_ctrl_data_user, dma_read_chnl_ready,
        output dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
        input  grant_id, busy, debug
    );

endinterface
`default_nettype wire

// File: rtl/dma64_read_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick : first active request at or after ptr, wrapping modulo N    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module rr_pick #(
    parameter int N_CLIENTS = 2,
    parameter int IDW       = 3
) (
    input  wire logic [N_CLIENTS-1:0] req,
    input  wire logic [IDW-1:0]       ptr,
    output logic      [IDW-1:0]       grant,
    output logic                      any_req
);

    // Scan distances from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        for (int k = N_CLIENTS - 1; k >= 0; k--) begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                if (req[i] && (((i + N_CLIENTS - int'(ptr)) % N_CLIENTS) == k)) begin
                    grant   = IDW'(i);
                    any_req = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma64_read_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dma64_read_arbiter : round-robin sharing of one ESP DMA64 read port  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module dma64_read_arbiter
    import dma64_arb_pkg::*;
#(
    parameter int N_CLIENTS = 2,
    parameter int IDW       = 3
) (
    input  wire logic            clk,
    input  wire logic            rst,
    dma64_read_arbiter_if.master bus
);

    state_t             r_state;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_grant;
    logic [IDX_W-1:0]   r_index;
    logic [LEN_W-1:0]   r_length;
    logic [2:0]         r_size;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_ctrl_valid;

    logic [IDW-1:0]       w_pick;
    logic                 w_any;
    logic [IDX_W-1:0]     w_sel_index;
    logic [LEN_W-1:0]     w_sel_length;
    logic [2:0]           w_sel_size;
    logic                 w_beat_rdy;
    logic                 w_beat_hs;
    logic [N_CLIENTS-1:0] w_ctrl_ready;
    logic [N_CLIENTS-1:0] w_chnl_valid;

    rr_pick #(
        .N_CLIENTS (N_CLIENTS),
        .IDW       (IDW)
    ) u_rr_pick (
        .req     (bus.cl_ctrl_valid),
        .ptr     (r_rr_ptr),
        .grant   (w_pick),
        .any_req (w_any)
    );

    function automatic logic [IDW-1:0] f_rr_next(input logic [IDW-1:0] g);
        return (g == IDW'(N_CLIENTS - 1)) ? '0 : g + IDW'(1);
    endfunction

    always_comb begin
        w_sel_index  = '0;
        w_sel_length = '0;
        w_sel_size   = '0;
        w_beat_rdy   = 1'b0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (w_pick == IDW'(i)) begin
                w_sel_index  = bus.cl_ctrl_index[IDX_W*i +: IDX_W];
                w_sel_length = bus.cl_ctrl_length[LEN_W*i +: LEN_W];
                w_sel_size   = bus.cl_ctrl_size[3*i +: 3];
            end
            if (r_grant == IDW'(i)) begin
                w_beat_rdy = bus.cl_chnl_ready[i];
            end
        end
    end

    // A zero-length request is acknowledged straight from IDLE without a master request.
    always_comb begin
        w_ctrl_ready = '0;
        w_chnl_valid = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if ((r_state == IDLE) && w_any && (w_pick == IDW'(i)) && (w_sel_length == '0)) begin
                w_ctrl_ready[i] = 1'b1;
            end
            if ((r_state == CTRL) && (r_grant == IDW'(i))) begin
                w_ctrl_ready[i] = bus.dma_read_ctrl_ready;
            end
            if ((r_state == DATA) && (r_grant == IDW'(i))) begin
                w_chnl_valid[i] = bus.dma_read_chnl_valid;
            end
        end
    end

    assign w_beat_hs = (r_state == DATA) && bus.dma_read_chnl_valid && w_beat_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_index      <= '0;
            r_length     <= '0;
            r_size       <= '0;
            r_cnt        <= '0;
            r_ctrl_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant  <= w_pick;
                        r_index  <= w_sel_index;
                        r_length <= w_sel_length;
                        r_size   <= w_sel_size;
                        if (w_sel_length != '0) begin
                            r_state      <= CTRL;
                            r_ctrl_valid <= 1'b1;
                        end else begin
                            r_rr_ptr <= f_rr_next(w_pick);
                        end
                    end
                end
                CTRL: begin
                    if (bus.dma_read_ctrl_ready) begin
                        r_ctrl_valid <= 1'b0;
                        r_cnt        <= r_length;
                        r_state      <= DATA;
                    end
                end
                DATA: begin
                    if (w_beat_hs) begin
                        r_cnt <= r_cnt - LEN_W'(1);
                        if (r_cnt == LEN_W'(1)) begin
                            r_state  <= IDLE;
                            r_rr_ptr <= f_rr_next(r_grant);
                        end
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_ctrl_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cl_ctrl_ready             = w_ctrl_ready;
    assign bus.cl_chnl_valid             = w_chnl_valid;
    assign bus.cl_chnl_data              = bus.dma_read_chnl_data;
    assign bus.dma_read_ctrl_valid       = r_ctrl_valid;
    assign bus.dma_read_ctrl_data_index  = r_index;
    assign bus.dma_read_ctrl_data_length = r_length;
    assign bus.dma_read_ctrl_data_size   = r_size;
    assign bus.dma_read_ctrl_data_user   = 6'd0;
    assign bus.dma_read_chnl_ready       = (r_state == DATA) && w_beat_rdy;
    assign bus.grant_id                  = r_grant;
    assign bus.busy                      = (r_state != IDLE);
    assign bus.debug                     = {29'd0, r_state};

endmodule
`default_nettype wire

// File: tb/tb_dma64_read_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dma64_read_arbiter : random clients and DMA port vs. a RR model   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_dma64_read_arbiter;
    import dma64_arb_pkg::*;

    localparam int N   = 3;
    localparam int IDW = 3;

    logic clk;
    logic rst_n;

    dma64_read_arbiter_if #(.N_CLIENTS(N), .IDW(IDW)) bus ();

    dma64_read_arbiter #(.N_CLIENTS(N), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: pending requests, round-robin pointer, in-flight burst.
    bit [N-1:0]  pend;
    int unsigned plen[N];
    logic [31:0] pidx[N];
    logic [2:0]  psize[N];
    int          bursts_left[N];
    int          m_ptr;
    int          cur_g;
    int unsigned cur_len;
    int unsigned m_left;
    int unsigned cl_cnt;
    logic [63:0] m_data;
    int          grants[$];
    bit          idle_chk;
    bit          gap_armed;
    int          gap_cnt;
    int          stall_cnt;
    int          stall_g;
    bit          stall_arm;
    int unsigned len_lo, len_hi;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int j = (m_ptr + k) % N;
            if (pend[j]) return j;
        end
        return -1;
    endfunction

    task automatic new_req(input int c);
        pend[c]  = 1'b1;
        plen[c]  = $urandom_range(len_hi, len_lo);
        pidx[c]  = $urandom;
        psize[c] = ($urandom_range(0, 1) == 0) ? DMA_SIZE_64 : 3'($urandom_range(0, 7));
    endtask

    task automatic clear_model();
        pend      = '0;
        m_ptr     = 0;
        cur_g     = 0;
        cur_len   = 0;
        m_left    = 0;
        cl_cnt    = 0;
        idle_chk  = 1'b0;
        gap_armed = 1'b0;
        gap_cnt   = 0;
        stall_cnt = 0;
        stall_arm = 1'b0;
        for (int i = 0; i < N; i++) bursts_left[i] = 0;
        grants.delete();
    endtask

    // Asserted between clock edges; outputs must settle without a clock.
    task automatic assert_reset();
        bus.dma_read_chnl_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_busy",      bus.busy, 0);
        check("rst_ctrl_vld",  bus.dma_read_ctrl_valid, 0);
        check("rst_index",     bus.dma_read_ctrl_data_index, 0);
        check("rst_length",    bus.dma_read_ctrl_data_length, 0);
        check("rst_size",      bus.dma_read_ctrl_data_size, 0);
        check("rst_grant",     bus.grant_id, 0);
        check("rst_debug",     bus.debug, 0);
        check("rst_chnl_rdy",  bus.dma_read_chnl_ready, 0);
        check("rst_cl_chnl",   bus.cl_chnl_valid, 0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        assert_reset();
    endtask

    task automatic tick();
        int acc, exp_g, nx, nacc;
        bit mhs, chs_cur, chs_oth, ctrl_hs, stall_now;
        logic [N-1:0] gmask;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            bus.cl_ctrl_valid[i]            = pend[i];
            bus.cl_ctrl_index[32*i +: 32]   = pidx[i];
            bus.cl_ctrl_length[32*i +: 32]  = plen[i];
            bus.cl_ctrl_size[3*i +: 3]      = psize[i];
            bus.cl_chnl_ready[i]            = ($urandom_range(0, 3) != 0);
        end
        gmask     = N'(1) << cur_g;
        stall_now = (stall_cnt > 0) && (m_left > 0);
        bus.dma_read_ctrl_ready = 1'($urandom_range(0, 1));
        if (stall_now)        bus.dma_read_chnl_valid = 1'b1;
        else if (m_left > 0)  bus.dma_read_chnl_valid = ($urandom_range(0, 3) != 0);
        else                  bus.dma_read_chnl_valid = ($urandom_range(0, 3) == 0);
        if (stall_now) bus.cl_chnl_ready = bus.cl_chnl_ready & ~gmask;
        bus.dma_read_chnl_data = m_data;
        #1;
        ctrl_hs = bus.dma_read_ctrl_valid && bus.dma_read_ctrl_ready;
        check("user_zero", bus.dma_read_ctrl_data_user, 0);

        if (m_left == 0 && bus.dma_read_chnl_valid)
            check("stray_beat", {bus.cl_chnl_valid, bus.dma_read_chnl_ready}, 0);
        if (stall_now) begin
            check("stall_mst_rdy", bus.dma_read_chnl_ready, 0);
            check("stall_cl_vld", |(bus.cl_chnl_valid & gmask), 1);
            stall_cnt--;
        end
        if (idle_chk) begin
            check("busy_after_last", bus.busy, 0);
            check("grant_hold", bus.grant_id, cur_g);
            idle_chk = 1'b0;
        end
        if (gap_armed) begin
            gap_cnt++;
            if (bus.dma_read_ctrl_valid || gap_cnt > 4) begin
                check("reissue_gap", gap_cnt, 2);
                gap_armed = 1'b0;
            end
        end

        if (m_left > 0) begin
            mhs     = bus.dma_read_chnl_valid && bus.dma_read_chnl_ready;
            chs_cur = |(bus.cl_chnl_valid & bus.cl_chnl_ready & gmask);
            chs_oth = |(bus.cl_chnl_valid & bus.cl_chnl_ready & ~gmask);
            if (mhs || chs_cur || chs_oth) check("beat_hs", {chs_oth, chs_cur}, {1'b0, mhs});
            if (mhs) begin
                if (chs_cur) begin
                    check("beat_data", bus.cl_chnl_data, m_data);
                    cl_cnt++;
                end
                m_left--;
                m_data = {$urandom, $urandom};
                if (m_left == 0) begin
                    check("beat_count", cl_cnt, cur_len);
                    m_ptr = (cur_g + 1) % N;
                    grants.push_back(cur_g);
                    idle_chk  = 1'b1;
                    nx        = pick();
                    gap_armed = (nx >= 0) && (plen[nx] != 0);
                    gap_cnt   = 0;
                end
            end
            if (stall_arm && cur_g == stall_g && cl_cnt == 2) begin
                stall_cnt = 5;
                stall_arm = 1'b0;
            end
        end

        acc  = -1;
        nacc = 0;
        for (int i = 0; i < N; i++) begin
            if (bus.cl_ctrl_ready[i]) begin
                nacc++;
                if (pend[i]) acc = i;
            end
        end
        if (nacc > 1) check("multi_ready", nacc, 1);
        if (acc < 0) begin
            check("ctrl_wo_accept", ctrl_hs, 0);
        end else begin
            exp_g = pick();
            check("grant_order", acc, exp_g);
            if (plen[acc] == 0) begin
                check("zero_no_ctrl", bus.dma_read_ctrl_valid, 0);
                m_ptr = (acc + 1) % N;
                grants.push_back(acc);
            end else begin
                check("ctrl_hs", ctrl_hs, 1);
                check("ctrl_index", bus.dma_read_ctrl_data_index, pidx[acc]);
                check("ctrl_length", bus.dma_read_ctrl_data_length, plen[acc]);
                check("ctrl_size", bus.dma_read_ctrl_data_size, psize[acc]);
                check("grant_id", bus.grant_id, acc);
                cur_g   = acc;
                cur_len = plen[acc];
                m_left  = plen[acc];
                cl_cnt  = 0;
            end
            pend[acc] = 1'b0;
            if (bursts_left[acc] > 0) begin
                bursts_left[acc]--;
                new_req(acc);
            end
        end
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while ((pend != 0 || m_left != 0) && n < budget) begin
            tick();
            n++;
        end
        check("done_in_budget", n < budget, 1);
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.cl_ctrl_valid = '0;
        bus.cl_ctrl_index = '0;
        bus.cl_ctrl_length = '0;
        bus.cl_ctrl_size = '0;
        bus.cl_chnl_ready = '0;
        bus.dma_read_ctrl_ready = 1'b0;
        bus.dma_read_chnl_valid = 1'b0;
        bus.dma_read_chnl_data = '0;
        m_data = 64'h0123_4567_89ab_cdef;
        for (int i = 0; i < N; i++) begin
            plen[i] = 0; pidx[i] = '0; psize[i] = '0;
        end
        clear_model();
        #12;
        do_reset();

        // Single client, index 0x10, four beats; ctrl valid one cycle after request.
        pend[0] = 1'b1; pidx[0] = 32'h10; plen[0] = 4; psize[0] = DMA_SIZE_64;
        tick();
        check("t1_no_ctrl_yet", bus.dma_read_ctrl_valid, 0);
        tick();
        check("t1_ctrl_latency", bus.dma_read_ctrl_valid, 1);
        run_until_done(500);
        check("t1_bursts", grants.size(), 1);

        // Two simultaneous requests after reset: client 0 then client 1.
        do_reset();
        len_lo = 3; len_hi = 3; new_req(0);
        len_lo = 2; len_hi = 2; new_req(1);
        run_until_done(500);
        check("t2_bursts", grants.size(), 2);
        check("t2_first", grants[0], 0);
        check("t2_second", grants[1], 1);

        // Client 1 backpressures for five cycles mid-burst.
        do_reset();
        len_lo = 8; len_hi = 8; new_req(1);
        stall_g = 1; stall_arm = 1'b1;
        run_until_done(500);
        check("t3_stall_done", stall_cnt, 0);

        // Zero-length request: pulse only, pointer advances past client 0.
        do_reset();
        pend[0] = 1'b1; plen[0] = 0; pidx[0] = 32'hdead; psize[0] = DMA_SIZE_64;
        tick();
        check("t4_zero_pulse", bus.cl_ctrl_ready, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t4_no_ctrl", bus.dma_read_ctrl_valid, 0);
        end
        len_lo = 2; len_hi = 2; new_req(0); new_req(1);
        run_until_done(500);
        check("t4_bursts", grants.size(), 3);
        check("t4_after_zero", grants[1], 1);

        // Reset in DATA with two beats remaining, then a fresh burst from client 1.
        do_reset();
        len_lo = 6; len_hi = 6; new_req(0);
        for (int k = 0; k < 500 && !(m_left == 2 && cl_cnt == 4); k++) tick();
        check("t5_reached_mid", m_left, 2);
        assert_reset();
        for (int k = 0; k < 3; k++) tick();
        len_lo = 3; len_hi = 3; new_req(1);
        run_until_done(500);
        check("t5_bursts", grants.size(), 1);
        check("t5_grant", grants[0], 1);

        // Two clients requesting continuously for six bursts alternate.
        do_reset();
        len_lo = 1; len_hi = 5;
        new_req(0); new_req(1);
        bursts_left[0] = 2; bursts_left[1] = 2;
        run_until_done(2000);
        check("t6_bursts", grants.size(), 6);
        for (int k = 0; k < 6; k++) check("t6_alternate", grants[k], k % 2);

        // Random mixes of requesters, lengths (including zero) and repeats.
        do_reset();
        len_lo = 0; len_hi = 6;
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    new_req(i);
                    bursts_left[i] = $urandom_range(0, 2);
                end
            end
            run_until_done(2000);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
